// File: rtl/pkt_egress_pkg.sv
// -----------------------------------------------------------------------------
// pkt_egress_pkg
// Shared types and constants for the packet egress framer.
//   egr_state_t  : framer FSM states (header parse / payload body)
//   HDR_LEN_LSB  : bit position of the packet length field in a header word
// -----------------------------------------------------------------------------
package pkt_egress_pkg;

  typedef enum logic {
    S_HDR  = 1'b0,
    S_BODY = 1'b1
  } egr_state_t;

  // The length field sits at the bottom of the header word; everything above
  // it is reserved and ignored by the framer.
  localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/pkt_egress_sync_fifo.sv
// -----------------------------------------------------------------------------
// pkt_egress_sync_fifo
// Single-clock FIFO with a combinational head read (first-word fall-through
// one cycle after the write edge).
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   clr         : synchronous clear (pointers and count to zero)
//   push, push_data : write request; ignored while full
//   pop         : remove head word; ignored while empty
//   head        : current head word (valid when !empty)
//   full, empty : status flags
//   count       : occupancy in words (0..FIFO_DEPTH)
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module pkt_egress_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clr,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            push_data,
  input  logic                             pop,
  output logic [DATA_WIDTH-1:0]            head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH):0]      count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // A push while full is dropped even if a pop happens in the same cycle;
  // the credit scheme upstream keeps that case from arising in normal use.
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; pointers define what is valid, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pkt_egress_framer.sv
// -----------------------------------------------------------------------------
// pkt_egress_framer
// Egress stage after the packet processor dequeue port. Requests words with a
// credit-limited deq_req, buffers them locally, strips the per-packet length
// header and presents the payload on a valid/ready stream with sop/eop/len.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   sw_rst      : synchronous clear, same effect as reset
//   deq_req     : request one word from upstream (registered)
//   in_valid, in_data : returned upstream word
//   out_valid, out_ready, out_data : payload stream
//   out_sop, out_eop  : first / last payload beat of a packet
//   out_len     : length of the current packet, held from sop through eop
//   len_err     : one-cycle pulse when a zero-length header is discarded
//   ovf_err     : sticky, a word arrived while the buffer was full
//   busy        : packet in progress, buffer non-empty or requests in flight
// Optional build macro PKT_EGRESS_FRAMER_STATS_EN adds:
//   pkt_cnt     : accepted eop beats (wraps at 2^32)
//   word_cnt    : accepted payload beats (wraps at 2^32)
// -----------------------------------------------------------------------------
module pkt_egress_framer
  import pkt_egress_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PCK_LEN    = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sw_rst,
  output logic                  deq_req,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [PCK_LEN-1:0]    out_len,
  output logic                  len_err,
  output logic                  ovf_err,
  output logic                  busy
`ifdef PKT_EGRESS_FRAMER_STATS_EN
  ,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           word_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  egr_state_t            state;
  egr_state_t            state_nxt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W:0]        credit_sum;
  logic [PCK_LEN-1:0]    hdr_len;
  logic [PCK_LEN-1:0]    remaining;
  logic                  first;
  logic                  hdr_take;
  logic                  beat;

  // Decrement that holds at zero: a stray in_valid with nothing outstanding
  // must not wrap the in-flight counter.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  pkt_egress_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (sw_rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign hdr_len = fifo_head[HDR_LEN_LSB +: PCK_LEN];

  // Words already buffered, words requested but not yet returned, and the
  // request going out this cycle all claim a buffer slot.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight} + (CNT_W+1)'(deq_req);

  // ---- Stage boundary: state register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       state <= S_HDR;
    else if (sw_rst) state <= S_HDR;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    hdr_take  = 1'b0;
    beat      = 1'b0;
    case (state)
      S_HDR: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hdr_take = 1'b1;
          if (hdr_len != '0) state_nxt = S_BODY;
        end
      end
      S_BODY: begin
        out_valid = ~fifo_empty;
        out_sop   = ~fifo_empty & first;
        out_eop   = ~fifo_empty & (remaining == PCK_LEN'(1));
        if (!fifo_empty && out_ready) begin
          fifo_pop = 1'b1;
          beat     = 1'b1;
          if (remaining == PCK_LEN'(1)) state_nxt = S_HDR;
        end
      end
      default: state_nxt = S_HDR;
    endcase
  end

  // Data is forced to zero outside a valid beat so reset and idle look clean.
  assign out_data = out_valid ? fifo_head : '0;
  assign busy     = (state == S_BODY) | ~fifo_empty | (inflight != '0);

  // ---- Stage boundary: credit, framing and error registers ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deq_req   <= 1'b0;
      inflight  <= '0;
      len_err   <= 1'b0;
      ovf_err   <= 1'b0;
      out_len   <= '0;
      remaining <= '0;
      first     <= 1'b0;
    end else if (sw_rst) begin
      deq_req   <= 1'b0;
      inflight  <= '0;
      len_err   <= 1'b0;
      ovf_err   <= 1'b0;
      out_len   <= '0;
      remaining <= '0;
      first     <= 1'b0;
    end else begin
      deq_req <= (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
      case ({deq_req, in_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= sat_dec(inflight);
        default: inflight <= inflight;
      endcase
      ovf_err <= ovf_err | (in_valid & fifo_full);
      len_err <= hdr_take & (hdr_len == '0);
      if (hdr_take && hdr_len != '0) begin
        out_len   <= hdr_len;
        remaining <= hdr_len;
        first     <= 1'b1;
      end else if (beat) begin
        remaining <= remaining - 1'b1;
        first     <= 1'b0;
      end
    end
  end

`ifdef PKT_EGRESS_FRAMER_STATS_EN
  // ---- Stage boundary: statistics counters ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt  <= '0;
      word_cnt <= '0;
    end else if (sw_rst) begin
      pkt_cnt  <= '0;
      word_cnt <= '0;
    end else if (beat) begin
      word_cnt <= word_cnt + 32'd1;
      if (out_eop) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_egress_framer.sv
// -----------------------------------------------------------------------------
// tb_pkt_egress_framer
// Bench for pkt_egress_framer. An upstream model answers deq_req after a
// random latency from a queue of header/payload words; a packet-level
// scoreboard lists the payload beats every packet must produce.
// -----------------------------------------------------------------------------
module tb_pkt_egress_framer;

  localparam int DW = 32;
  localparam int PL = 12;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sw_rst;
  logic          deq_req;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [PL-1:0] out_len;
  logic          len_err;
  logic          ovf_err;
  logic          busy;
`ifdef PKT_EGRESS_FRAMER_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [31:0]   word_cnt;
`endif

  pkt_egress_framer #(
    .DATA_WIDTH (DW),
    .PCK_LEN    (PL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sw_rst    (sw_rst),
    .deq_req   (deq_req),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_len   (out_len),
    .len_err   (len_err),
    .ovf_err   (ovf_err),
    .busy      (busy)
`ifdef PKT_EGRESS_FRAMER_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .word_cnt  (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [PL-1:0] len;
    bit            sop;
    bit            eop;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] src_q[$];
  int            due_q[$];
  int            last_due;
  int            lat_min, lat_max;
  bit            rdy_rand;
  int            exp_lenerr, seen_lenerr;
  int            acc_beats, acc_pkts;
  int            first_in, first_out;
  bit            prev_hold;
  beat_t         prev_b;
  int            errs = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Queue one packet: header (length plus arbitrary reserved upper bits) then
  // payload. base != 0 gives payload base+1, base+2, ...; otherwise random.
  task automatic add_pkt(input int len, input logic [DW-1:0] upper, input logic [DW-1:0] base);
    beat_t b;
    src_q.push_back((upper << PL) | DW'(len));
    if (len == 0) exp_lenerr++;
    for (int i = 0; i < len; i++) begin
      b.data = (base != 0) ? base + DW'(i + 1) : DW'($urandom);
      b.len  = PL'(len);
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      src_q.push_back(b.data);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    src_q.delete();
    due_q.delete();
    last_due    = 0;
    exp_lenerr  = 0;
    seen_lenerr = 0;
    acc_beats   = 0;
    acc_pkts    = 0;
    first_in    = -1;
    first_out   = -1;
    prev_hold   = 1'b0;
  endtask

  // One clock: drive upstream/consumer just after the edge, observe at negedge.
  task automatic cycle();
    beat_t e;
    int lat, d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src_q.pop_front();
      end
    end
    out_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    @(negedge clk);
    if (in_valid && first_in < 0) first_in = cyc;
    if (out_valid && first_out < 0) first_out = cyc;
    if (deq_req) begin
      lat = $urandom_range(lat_max, lat_min);
      d = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      due_q.push_back(d);
      last_due = d;
    end
    if (len_err) seen_lenerr++;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_b.data);
      chk("hold_sop", out_sop, prev_b.sop);
      chk("hold_eop", out_eop, prev_b.eop);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", out_data, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_sop", out_sop, e.sop);
        chk("beat_eop", out_eop, e.eop);
        chk("beat_len", out_len, e.len);
        acc_beats++;
        if (e.eop) acc_pkts++;
      end
    end
    prev_hold   = out_valid && !out_ready;
    prev_b.data = out_data;
    prev_b.sop  = out_sop;
    prev_b.eop  = out_eop;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_len_err_cnt"}, seen_lenerr, exp_lenerr);
  endtask

  task automatic do_sw_rst();
    @(posedge clk); #1;
    sw_rst   = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk("swrst_deq_req", deq_req, 0);
    chk("swrst_ovf_err", ovf_err, 0);
    chk("swrst_busy", busy, 0);
    chk("swrst_out_valid", out_valid, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_deq_req"}, deq_req, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sop"}, out_sop, 0);
    chk({tag, "_out_eop"}, out_eop, 0);
    chk({tag, "_out_len"}, out_len, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_ovf_err"}, ovf_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    rstn      = 1'b0;
    sw_rst    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rdy_rand  = 1'b0;
    lat_min   = 2;
    lat_max   = 2;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("por");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("por_release_deq_req", deq_req, 1);

    // Single 3-word packet, fixed 2-cycle upstream latency, always ready.
    do_sw_rst();
    add_pkt(3, '0, 32'hA0);
    run_until_done("single", 200);
    chk("single_latency", first_out - first_in, 2);
    chk("single_pkts", acc_pkts, 1);

    // Zero-length header is discarded, then a 1-word packet.
    do_sw_rst();
    add_pkt(0, '0, '0);
    add_pkt(1, '0, 32'h54);
    run_until_done("zero_len", 200);
    chk("zero_len_beats", acc_beats, 1);

    // Backpressure on a 4-word packet with random consumer readiness.
    do_sw_rst();
    rdy_rand = 1'b1;
    add_pkt(4, 20'hABCDE, '0);
    run_until_done("bp", 400);
    chk("bp_ovf_err", ovf_err, 0);

    // Randomised traffic: lengths 0..6, reserved header bits, latency 1..4.
    do_sw_rst();
    lat_min = 1;
    lat_max = 4;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(6, 0);
      if (p == 29 && len == 0) len = 3;
      add_pkt(len, DW'($urandom), '0);
    end
    run_until_done("rand", 6000);
    chk("rand_ovf_err", ovf_err, 0);

    // Asynchronous reset in the middle of a packet.
    do_sw_rst();
    add_pkt(6, '0, '0);
    add_pkt(5, '0, '0);
    repeat (12) cycle();
    #3;
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    chk("async_rst_release_deq_req", deq_req, 1);

    // Statistics: packets of 1, 2 and 5 words.
    do_sw_rst();
    add_pkt(1, '0, '0);
    add_pkt(2, '0, '0);
    add_pkt(5, '0, '0);
    run_until_done("stats", 1000);
    chk("stats_bench_words", acc_beats, 8);
`ifdef PKT_EGRESS_FRAMER_STATS_EN
    chk("stats_pkt_cnt", pkt_cnt, 3);
    chk("stats_word_cnt", word_cnt, 8);
`endif

    // Overflow: upstream ignores credits, consumer stalls. The first word is
    // taken as a header, so the buffer fills after nine writes and the tenth
    // is dropped.
    do_sw_rst();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = 32'h0000_0FFF + DW'(i);
      out_ready = 1'b0;
      @(negedge clk);
      if (i == 9) chk("ovf_before_drop", ovf_err, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", ovf_err, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf_sticky", ovf_err, 1);
    chk("ovf_full_busy", busy, 1);
    do_sw_rst();
    chk("ovf_cleared_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
